tm1638_ctrl: RTL and testbench

- Serial link controller between the display/LED/key logic and a TM1638 board.
- Continuously refreshes 8 seven-segment digits and 8 LEDs over the TM1638 STB/CLK/DIO interface.
- Reads the key matrix back on every frame and presents it as a parallel key vector.
- Sits directly downstream of the display driver, which supplies per-digit segment bytes and LED bits, and upstream of it for the key inputs.

---
 rtl/tm1638_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_tm1638_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_ctrl.sv
// tm1638_ctrl: serial link controller for a TM1638 display/LED/key board.
// Every frame writes 8 segment bytes and 8 LED bits, sets display brightness
// and reads the 4-byte key scan, presenting the keys as a parallel vector.
//
// Ports:
//   clk, rst       system clock, asynchronous active-low reset
//   segs[63:0]     digit i segment byte at [8i+7:8i], hgfedcba, 1 = lit
//   leds[7:0]      LED i lit when leds[i] = 1
//   keys[7:0]      key state, updated once per frame, 1 = pressed
//   frame_done     one-cycle pulse when keys is updated
//   tm_stb         TM1638 STB (active-low)
//   tm_clk         TM1638 CLK
//   tm_dio_out     DIO drive value
//   tm_dio_oe      DIO output enable (tristate built at the top level)
//   tm_dio_in      DIO sampled value
module tm1638_ctrl #(
    parameter int unsigned clk_mhz         = 27,
    parameter int unsigned sclk_khz        = 500,
    parameter int unsigned brightness      = 7,
    parameter int unsigned read_wait_ticks = 2  // must be >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] segs,
    input  logic [7:0]  leds,
    output logic [7:0]  keys,
    output logic        frame_done,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio_out,
    output logic        tm_dio_oe,
    input  logic        tm_dio_in
);

    localparam int unsigned HalfRaw  = (clk_mhz * 1000) / (2 * sclk_khz);
    localparam int unsigned Half     = (HalfRaw < 1) ? 1 : HalfRaw;
    localparam logic [15:0] HalfLast = 16'(Half - 1);
    localparam logic [7:0]  WaitLast = 8'(read_wait_ticks - 1);
    localparam logic [2:0]  Bright   = 3'(brightness);

    typedef enum logic [2:0] {
        StGap, StCmdWr, StData, StCmdDisp, StCmdRd, StRdWait, StRead, StStop
    } state_e;

    // Half-period tick generator
    logic [15:0] div_q;
    logic        tick;

    assign tick = (div_q == HalfLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

    state_e      state_q;
    state_e      next_q;      // command to start once the GAP expires
    logic        gap_q;
    logic [3:0]  tick_idx_q;  // tick within the current byte (even: CLK low, odd: CLK high)
    logic [4:0]  byte_idx_q;
    logic [7:0]  shreg_q;
    logic [7:0]  wait_cnt_q;
    logic [63:0] seg_q;
    logic [7:0]  led_q;
    logic [7:0]  kv_q;        // key vector being assembled during READ

    // Next DATA byte: address byte_idx_q, even = segment byte, odd = LED bit
    logic [7:0] next_data;
    logic [7:0] first_byte;

    always_comb begin
        next_data = '0;
        if (byte_idx_q[0]) begin
            next_data = {7'b0, led_q[byte_idx_q[3:1]]};
        end else begin
            next_data = seg_q[{byte_idx_q[3:1], 3'b000} +: 8];
        end
    end

    always_comb begin
        first_byte = 8'h42;
        case (next_q)
            StCmdWr:   first_byte = 8'h40;
            StData:    first_byte = 8'hC0;
            StCmdDisp: first_byte = {5'b10001, Bright};
            default:   first_byte = 8'h42;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StGap;
            next_q     <= StCmdWr;
            gap_q      <= 1'b0;
            tick_idx_q <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            wait_cnt_q <= '0;
            seg_q      <= '0;
            led_q      <= '0;
            kv_q       <= '0;
            keys       <= '0;
            frame_done <= 1'b0;
            tm_stb     <= 1'b1;
            tm_clk     <= 1'b1;
            tm_dio_out <= 1'b1;
            tm_dio_oe  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    StGap: begin
                        if (!gap_q) begin
                            gap_q <= 1'b1;
                        end else begin
                            // STB falls one tick ahead of the first CLK low
                            tm_stb     <= 1'b0;
                            tm_dio_oe  <= 1'b1;
                            state_q    <= next_q;
                            tick_idx_q <= '0;
                            byte_idx_q <= '0;
                            shreg_q    <= first_byte;
                            if (next_q == StCmdWr) begin
                                seg_q <= segs;
                                led_q <= leds;
                            end
                        end
                    end
                    StCmdWr, StData, StCmdDisp, StCmdRd: begin
                        tick_idx_q <= tick_idx_q + 4'd1;
                        if (!tick_idx_q[0]) begin
                            tm_clk     <= 1'b0;
                            tm_dio_out <= shreg_q[tick_idx_q[3:1]];
                        end else begin
                            tm_clk <= 1'b1;
                            if (tick_idx_q == 4'd15) begin
                                if (state_q == StData && !byte_idx_q[4]) begin
                                    shreg_q    <= next_data;
                                    byte_idx_q <= byte_idx_q + 5'd1;
                                end else if (state_q == StCmdRd) begin
                                    state_q    <= StRdWait;
                                    wait_cnt_q <= '0;
                                end else begin
                                    state_q <= StStop;
                                    if (state_q == StCmdWr) begin
                                        next_q <= StData;
                                    end else if (state_q == StData) begin
                                        next_q <= StCmdDisp;
                                    end else begin
                                        next_q <= StCmdRd;
                                    end
                                end
                            end
                        end
                    end
                    StRdWait: begin
                        // Release DIO after the last 0x42 rising edge, not on it
                        tm_dio_oe <= 1'b0;
                        if (wait_cnt_q == WaitLast) begin
                            state_q    <= StRead;
                            tick_idx_q <= '0;
                            byte_idx_q <= '0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 8'd1;
                        end
                    end
                    StRead: begin
                        tick_idx_q <= tick_idx_q + 4'd1;
                        if (!tick_idx_q[0]) begin
                            tm_clk <= 1'b0;
                        end else begin
                            tm_clk <= 1'b1;
                            // Byte b: bit0 -> key 2b, bit4 -> key 2b+1
                            if (tick_idx_q[3:1] == 3'd0) begin
                                kv_q[{byte_idx_q[1:0], 1'b0}] <= tm_dio_in;
                            end else if (tick_idx_q[3:1] == 3'd4) begin
                                kv_q[{byte_idx_q[1:0], 1'b1}] <= tm_dio_in;
                            end
                            if (tick_idx_q == 4'd15) begin
                                if (byte_idx_q[1:0] == 2'd3) begin
                                    state_q <= StStop;
                                    next_q  <= StCmdWr;
                                end else begin
                                    byte_idx_q <= byte_idx_q + 5'd1;
                                end
                            end
                        end
                    end
                    StStop: begin
                        tm_stb     <= 1'b1;
                        tm_dio_oe  <= 1'b1;
                        tm_dio_out <= 1'b1;
                        state_q    <= StGap;
                        gap_q      <= 1'b0;
                        // Only the read command is followed by CMD_WR
                        if (next_q == StCmdWr) begin
                            keys       <= kv_q;
                            frame_done <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tm1638_ctrl.sv
// Testbench for tm1638_ctrl: decodes the serial stream, models the key
// readback on DIO, and checks frames against a scoreboard queue.
module tb_tm1638_ctrl;

    localparam int unsigned ClkMhz   = 2;
    localparam int unsigned SclkKhz  = 500;
    localparam int unsigned Bright   = 7;
    localparam int unsigned Rwt      = 2;
    localparam int unsigned HalfCyc  = 2;
    localparam int unsigned FrameCyc = HalfCyc * (24 * 16 + Rwt + 4 * 3);
    localparam int          Budget   = 2000;

    logic        clk;
    logic        rst;
    logic [63:0] segs;
    logic [7:0]  leds;
    logic [7:0]  keys;
    logic        frame_done;
    logic        tm_stb;
    logic        tm_clk;
    logic        tm_dio_out;
    logic        tm_dio_oe;
    logic        tm_dio_in;

    tm1638_ctrl #(
        .clk_mhz        (ClkMhz),
        .sclk_khz       (SclkKhz),
        .brightness     (Bright),
        .read_wait_ticks(Rwt)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .segs      (segs),
        .leds      (leds),
        .keys      (keys),
        .frame_done(frame_done),
        .tm_stb    (tm_stb),
        .tm_clk    (tm_clk),
        .tm_dio_out(tm_dio_out),
        .tm_dio_oe (tm_dio_oe),
        .tm_dio_in (tm_dio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- bus monitor and DIO key model ----------------
    logic [7:0] got_q[$];
    logic [7:0] rd_cur[4];
    int         rd_rises;
    int         last_wr_rise;
    int         first_rd_fall;

    initial begin
        logic [7:0] wr_sh;
        int         wr_bits;
        int         rbit;
        logic       prev_clk;
        logic       prev_stb;
        wr_sh = '0; wr_bits = 0; rbit = 0; prev_clk = 1'b1; prev_stb = 1'b1;
        rd_rises = 0; last_wr_rise = 0; first_rd_fall = 0;
        tm_dio_in = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_bits = 0;
                rbit    = 0;
            end else if (tm_stb) begin
                wr_bits = 0;
                rbit    = 0;
            end else begin
                if (prev_stb) rd_rises = 0;
                if (tm_clk && !prev_clk) begin
                    if (tm_dio_oe) begin
                        wr_sh = {tm_dio_out, wr_sh[7:1]};
                        wr_bits++;
                        last_wr_rise = cyc;
                        if (wr_bits == 8) begin
                            got_q.push_back(wr_sh);
                            wr_bits = 0;
                        end
                    end else begin
                        rd_rises++;
                    end
                end
                if (!tm_clk && prev_clk && !tm_dio_oe && rbit < 32) begin
                    if (rbit == 0) first_rd_fall = cyc;
                    tm_dio_in = rd_cur[rbit / 8][rbit % 8];
                    rbit++;
                end
            end
            prev_clk = tm_clk;
            prev_stb = tm_stb;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];

    task automatic push_frame(input logic [63:0] s, input logic [7:0] l);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(s[8*i +: 8]);
            exp_q.push_back({7'b0, l[i]});
        end
        exp_q.push_back(8'(8'h88 | Bright));
        exp_q.push_back(8'h42);
    endtask

    task automatic compare_frame(input int base, input logic [7:0] exp_keys);
        logic [7:0] e;
        logic [7:0] g;
        check("byte_count", 64'(got_q.size() - base), 64'd20);
        for (int i = 0; i < 20; i++) begin
            e = exp_q.pop_front();
            g = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
            check($sformatf("stream_byte%0d", i), 64'(g), 64'(e));
        end
        check("keys", 64'(keys), 64'(exp_keys));
        check("read_clocks_oe0", 64'(rd_rises), 64'd32);
        check("read_wait_ok", 64'((first_rd_fall - last_wr_rise) >= int'(Rwt * HalfCyc)), 64'd1);
    endtask

    int fd_cyc;

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < Budget) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            n_vec++;
            n_fail++;
            $display("FAIL frame_timeout: got no frame_done required one within %0d cycles", Budget);
        end
        fd_cyc = cyc;
        @(negedge clk);
        check("frame_done_pulse", 64'(frame_done), 64'd0);
    endtask

    task automatic wait_bytes(input int target);
        int n;
        n = 0;
        while (got_q.size() < target && n < Budget) begin
            @(negedge clk);
            n++;
        end
        check("reached_byte", 64'(got_q.size() >= target), 64'd1);
    endtask

    typedef struct {
        logic [63:0] s;
        logic [7:0]  l;
        logic [31:0] rd;  // {byte3, byte2, byte1, byte0}
        logic [7:0]  k;
    } vec_t;

    vec_t tbl[4];

    task automatic set_rd(input logic [31:0] rd);
        for (int b = 0; b < 4; b++) rd_cur[b] = rd[8*b +: 8];
    endtask

    initial begin
        int base;
        int prev_fd;
        tbl[0] = '{s: 64'h0600_0000_0000_003F, l: 8'h81, rd: 32'h1100_1001, k: 8'hC9};
        tbl[1] = '{s: 64'h0123_4567_89AB_CDEF, l: 8'h5A, rd: 32'h1111_1111, k: 8'hFF};
        tbl[2] = '{s: 64'h0,                   l: 8'h00, rd: 32'h0000_0000, k: 8'h00};
        tbl[3] = '{s: 64'hFFFF_FFFF_FFFF_FFFF, l: 8'hFF, rd: 32'h00EE_0110, k: 8'h06};

        rst = 1'b0; segs = '0; leds = '0;
        set_rd(32'h0);
        repeat (3) @(negedge clk);
        check("rst_stb", 64'(tm_stb), 64'd1);
        check("rst_clk", 64'(tm_clk), 64'd1);
        check("rst_dout", 64'(tm_dio_out), 64'd1);
        check("rst_oe", 64'(tm_dio_oe), 64'd0);
        check("rst_keys", 64'(keys), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);

        base = got_q.size();
        push_frame(64'h0, 8'h0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("gap_stb", 64'(tm_stb), 64'd1);
            check("gap_clk", 64'(tm_clk), 64'd1);
            check("gap_oe", 64'(tm_dio_oe), 64'd0);
        end
        @(negedge clk);
        check("stb_fall_after_gap", 64'(tm_stb), 64'd0);

        wait_frame();
        compare_frame(base, 8'h00);
        prev_fd = fd_cyc;

        // Table-driven frames, back to back
        for (int v = 0; v < 4; v++) begin
            segs = tbl[v].s;
            leds = tbl[v].l;
            set_rd(tbl[v].rd);
            base = got_q.size();
            push_frame(tbl[v].s, tbl[v].l);
            wait_frame();
            check("frame_period", 64'(fd_cyc - prev_fd), 64'(FrameCyc));
            prev_fd = fd_cyc;
            compare_frame(base, tbl[v].k);
        end

        // Snapshot: change inputs in the middle of DATA
        segs = 64'h1122_3344_5566_7788;
        leds = 8'h0F;
        set_rd(32'h0000_0011);
        base = got_q.size();
        push_frame(64'h1122_3344_5566_7788, 8'h0F);
        wait_bytes(base + 6);
        segs = 64'hA1B2_C3D4_E5F6_0718;
        leds = 8'hF0;
        wait_frame();
        compare_frame(base, 8'h03);
        base = got_q.size();
        push_frame(64'hA1B2_C3D4_E5F6_0718, 8'hF0);
        wait_frame();
        compare_frame(base, 8'h03);

        // Reset during DATA byte 5
        set_rd(32'h1111_1111);
        base = got_q.size();
        wait_bytes(base + 7);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_stb", 64'(tm_stb), 64'd1);
        check("mid_rst_clk", 64'(tm_clk), 64'd1);
        check("mid_rst_oe", 64'(tm_dio_oe), 64'd0);
        check("mid_rst_keys", 64'(keys), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        base = got_q.size();
        push_frame(64'hA1B2_C3D4_E5F6_0718, 8'hF0);
        wait_frame();
        compare_frame(base, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
